udp_tx_arbiter: RTL
===================

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of application requesters, fixed at 4 in this revision.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: consecutive stall cycles that abort a granted packet.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 req_tdata_in  input  32  byte lane i = bits [8i+7:8i], requester i.
REQ-006 req_tvalid_in  input  4  per-requester valid.
REQ-007 req_tlast_in  input  4  per-requester last byte of packet.
REQ-008 req_tready_out  output  4  per-requester ready.
REQ-009 req_dest_port_in  input  64  dest port, lane i = [16i+15:16i].
REQ-010 req_src_port_in  input  64  source port, same lane layout.
REQ-011 req_enable_in  input  4  requester i is eligible for grant when 1.
REQ-012 udp_tx_tdata_out  output  8  payload byte to UDP transmit path.
REQ-013 udp_tx_tvalid_out  output  1  payload valid.
REQ-014 udp_tx_tlast_out  output  1  last payload byte.
REQ-015 udp_tx_tready_in  input  1  UDP transmit path ready.
REQ-016 udp_tx_dest_port_out  output  16  dest port latched at grant.
REQ-017 udp_tx_src_port_out  output  16  source port latched at grant.
REQ-018 grant_id_out  output  2  index of current/last granted requester.
REQ-019 abort_out  output  1  one-cycle pulse when a packet is aborted by timeout.
REQ-020 pkt_cnt_out  output  16  packets completed (normal tlast handshake), wraps 0xFFFF->0.

Function
REQ-021 FSM states: IDLE, XFER, ABORT, FLUSH.
REQ-022 IDLE: outputs tvalid=0, all req_tready=0; if any i has req_tvalid_in[i]&req_enable_in[i], grant first such i searching round-robin from (last_grant+1) mod 4, latch grant_id, dest/src port of i, go XFER next cycle (1-cycle arbitration latency).
REQ-023 XFER: combinational pass-through from granted lane: udp_tx_tdata/tvalid/tlast = lane grant; req_tready_out[grant] = udp_tx_tready_in; other readies 0.
REQ-024 XFER: beat accepted (tvalid&tready) with tlast -> IDLE, last_grant <= grant, pkt_cnt_out += 1.
REQ-025 Deasserting req_enable_in[grant] mid-packet SHALL NOT affect the packet; it completes normally.
REQ-026 Stall counter counts XFER cycles with granted tvalid=0, clears on any granted tvalid=1; udp_tx_tready_in=0 backpressure SHALL NOT count.
REQ-027 Stall counter reaching TIMEOUT_CYCLES -> ABORT; abort_out pulses 1 cycle on this entry.
REQ-028 ABORT: drive tvalid=1, tlast=1, tdata=0x00, all req_tready=0; on udp_tx_tready_in=1 go FLUSH; pkt_cnt_out unchanged.
REQ-029 FLUSH: req_tready_out[grant]=1, output tvalid=0, bytes discarded; granted tvalid&tlast -> IDLE, last_grant <= grant.
REQ-030 Port outputs SHALL hold latched values until next grant.
REQ-031 Simultaneous requests: exactly one grant per IDLE cycle, strict rotation; no requester waits more than 3 other packets.

Reset
REQ-032 reset_n=0 at a clock edge: state IDLE, last_grant=3 (so requester 0 is first priority), grant_id_out=0, ports=0, pkt_cnt_out=0, stall counter=0, abort_out=0, all tvalid/tready outputs 0.
REQ-033 Reset mid-packet SHALL drop the transfer immediately with no tlast emitted; next cycle after release is IDLE.

Verification
REQ-034 Requester 2 alone sends 5-byte packet 0x11..0x15, dest 0x1F90, tready=1 -> grant_id=2 after 1 cycle, 5 bytes in order, tlast on 0x15, dest_out=0x1F90, pkt_cnt=1.
REQ-035 All 4 request continuously with 3-byte packets after reset -> grant order 0,1,2,3,0; pkt_cnt=5 after five packets.
REQ-036 Requester 1 mid-packet, udp_tx_tready_in=0 for 2000 cycles -> no abort, bytes resume intact.
REQ-037 Requester 3 sends 2 bytes then tvalid=0 for 1024 cycles -> abort_out pulse, output 0x00 with tlast, remaining bytes up to its tlast consumed and not forwarded, pkt_cnt unchanged.
REQ-038 req_enable_in=4'b1011 with all requesting -> requester 2 never granted; clearing enable[0] mid-packet lets that packet finish.
REQ-039 reset_n=0 during byte 3 of a 6-byte packet -> all outputs zero next cycle, pkt_cnt=0, requester 0 granted first after release.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter
//   Round-robin arbiter that merges NUM_REQ byte-wide AXI-Stream requesters
//   into one UDP transmit stream. A grant lasts for a whole packet. The
//   destination and source ports are latched when the grant is made. A granted
//   requester that stops supplying data for TIMEOUT_CYCLES consecutive cycles
//   has its packet ended early: one 0x00 byte with tlast is sent downstream,
//   and the rest of that packet is then drained from the requester.
//
// Ports
//   clk, reset_n            : single clock, synchronous active-low reset
//   req_tdata_in            : byte lane i = [8i+7:8i]
//   req_tvalid_in/tlast_in  : per-requester stream qualifiers
//   req_tready_out          : per-requester ready (only the granted lane can be 1)
//   req_dest/src_port_in    : 16-bit port lanes, lane i = [16i+15:16i]
//   req_enable_in           : requester i may win arbitration when 1
//   udp_tx_*                : merged output stream and latched ports
//   grant_id_out            : current or most recent grant
//   abort_out               : one-cycle pulse when a packet is aborted
//   pkt_cnt_out             : count of packets that completed normally (wraps)
module udp_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ*8-1:0]         req_tdata_in,
  input  logic [NUM_REQ-1:0]           req_tvalid_in,
  input  logic [NUM_REQ-1:0]           req_tlast_in,
  output logic [NUM_REQ-1:0]           req_tready_out,
  input  logic [NUM_REQ*16-1:0]        req_dest_port_in,
  input  logic [NUM_REQ*16-1:0]        req_src_port_in,
  input  logic [NUM_REQ-1:0]           req_enable_in,
  output logic [7:0]                   udp_tx_tdata_out,
  output logic                         udp_tx_tvalid_out,
  output logic                         udp_tx_tlast_out,
  input  logic                         udp_tx_tready_in,
  output logic [15:0]                  udp_tx_dest_port_out,
  output logic [15:0]                  udp_tx_src_port_out,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id_out,
  output logic                         abort_out,
  output logic [15:0]                  pkt_cnt_out
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, XFER, ABORT, FLUSH} state_t;

  state_t state, state_nxt;

  logic [NUM_REQ-1:0][7:0]  lane_data;
  logic [NUM_REQ-1:0][15:0] lane_dest;
  logic [NUM_REQ-1:0][15:0] lane_src;

  assign lane_data = req_tdata_in;
  assign lane_dest = req_dest_port_in;
  assign lane_src  = req_src_port_in;

  logic [GW-1:0] grant, last_grant, pick;
  logic          pick_vld;
  logic [SW-1:0] stall_cnt;

  logic g_vld, g_last, beat, timeout;

  assign g_vld   = req_tvalid_in[grant];
  assign g_last  = req_tlast_in[grant];
  assign beat    = g_vld & udp_tx_tready_in;
  // Only cycles where the granted source has no data count as stall cycles.
  // Downstream backpressure never counts.
  assign timeout = ~g_vld & (stall_cnt == SW'(TIMEOUT_CYCLES - 1));

  // Round-robin search starting at last_grant+1. The loop runs from the
  // farthest candidate to the nearest, so the nearest eligible requester is
  // written last and wins.
  always_comb begin
    logic [GW-1:0] idx;
    idx      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = GW'((int'(last_grant) + off) % NUM_REQ);
      if (req_tvalid_in[idx] && req_enable_in[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    udp_tx_tdata_out  = 8'h00;
    udp_tx_tvalid_out = 1'b0;
    udp_tx_tlast_out  = 1'b0;
    req_tready_out    = '0;
    case (state)
      IDLE: if (pick_vld) state_nxt = XFER;
      XFER: begin
        udp_tx_tdata_out      = lane_data[grant];
        udp_tx_tvalid_out     = g_vld;
        udp_tx_tlast_out      = g_last;
        req_tready_out[grant] = udp_tx_tready_in;
        if (beat && g_last) state_nxt = IDLE;
        else if (timeout)   state_nxt = ABORT;
      end
      ABORT: begin
        // Close the downstream packet with a 0x00 terminator byte.
        udp_tx_tvalid_out = 1'b1;
        udp_tx_tlast_out  = 1'b1;
        if (udp_tx_tready_in) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Drain the rest of the aborted packet from the requester.
        // Nothing is forwarded downstream.
        req_tready_out[grant] = 1'b1;
        if (g_vld && g_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                <= IDLE;
      grant                <= '0;
      last_grant           <= GW'(NUM_REQ - 1);
      udp_tx_dest_port_out <= '0;
      udp_tx_src_port_out  <= '0;
      pkt_cnt_out          <= '0;
      stall_cnt            <= '0;
      abort_out            <= 1'b0;
    end else begin
      state     <= state_nxt;
      abort_out <= (state == XFER) && timeout;
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (pick_vld) begin
            grant                <= pick;
            udp_tx_dest_port_out <= lane_dest[pick];
            udp_tx_src_port_out  <= lane_src[pick];
          end
        end
        XFER: begin
          if (g_vld || timeout) stall_cnt <= '0;
          else                  stall_cnt <= stall_cnt + 1'b1;
          if (beat && g_last) begin
            last_grant  <= grant;
            pkt_cnt_out <= pkt_cnt_out + 16'd1;
          end
        end
        FLUSH: if (g_vld && g_last) last_grant <= grant;
        default: ;
      endcase
    end
  end

  assign grant_id_out = grant;

endmodule
